// File: rtl/h264buffer_sched.sv
// h264buffer_sched: macroblock grant/position sequencer for the inter-path coefficient buffer.
// Optional statistics outputs (STALL_CNT, MB_CNT) are enabled by H264BUFFER_SCHED_STATS_EN.
module h264buffer_sched #(
    parameter int MBW_BITS   = 8,
    parameter int SLOTS      = 2,
    parameter int SLICE_BITS = 16
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic [MBW_BITS-1:0]   MBW,
    input  logic [MBW_BITS-1:0]   MBH,
    input  logic [SLICE_BITS-1:0] SLICE_MBS,
    input  logic                  MBIN_REQ,
    output logic                  MBIN_GNT,
    input  logic                  MBIN_END,
    input  logic                  MBOUT_END,
    input  logic                  BUF_DONE,
    output logic                  NEWSLICE,
    output logic                  NEWLINE,
    output logic [MBW_BITS-1:0]   MBX,
    output logic [MBW_BITS-1:0]   MBY,
    output logic                  BUSY,
    output logic                  FRAME_DONE
`ifdef H264BUFFER_SCHED_STATS_EN
    ,
    output logic [15:0]           STALL_CNT,
    output logic [15:0]           MB_CNT
`endif
);

    localparam int CW = $clog2(SLOTS + 1) + 1;
    localparam logic [CW-1:0] SLOTS_C = CW'(SLOTS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRAIN,
        S_SLICE,
        S_RUN,
        S_LINE,
        S_FLUSH
    } state_t;

    state_t                state_q, state_d;
    logic [MBW_BITS-1:0]   mbw_q, mbw_d, mbh_q, mbh_d;
    logic [SLICE_BITS-1:0] slice_mbs_q, slice_mbs_d;
    logic [SLICE_BITS-1:0] slice_cnt_q, slice_cnt_d, slice_inc;
    logic [MBW_BITS-1:0]   nx_q, nx_d, ny_q, ny_d;
    logic [MBW_BITS-1:0]   mbx_q, mbx_d, mby_q, mby_d;
    logic [CW-1:0]         credits_q, credits_d;
    logic [CW-1:0]         inflight_q, inflight_d;
    logic [CW-1:0]         pend_q, pend_d;
    logic                  gnt_q, gnt_d;
    logic                  grant, ack_end, ack_rd, last_col, last_row;

`ifdef H264BUFFER_SCHED_STATS_EN
    logic [15:0] stall_q, stall_d, mbcnt_q, mbcnt_d;
`endif

    always_comb begin
        state_d     = state_q;
        mbw_d       = mbw_q;
        mbh_d       = mbh_q;
        slice_mbs_d = slice_mbs_q;
        slice_cnt_d = slice_cnt_q;
        nx_d        = nx_q;
        ny_d        = ny_q;
        mbx_d       = mbx_q;
        mby_d       = mby_q;
        credits_d   = credits_q;
        inflight_d  = inflight_q;
        pend_d      = pend_q;
        MBIN_GNT    = 1'b0;
        NEWSLICE    = 1'b0;
        NEWLINE     = 1'b0;
        FRAME_DONE  = 1'b0;
        BUSY        = (state_q != S_IDLE);

        // An end/read pulse is only honoured when there is something for it to retire.
        ack_end   = MBIN_END && (pend_q != '0);
        ack_rd    = MBOUT_END && (inflight_q != '0);
        grant     = (state_q == S_RUN) && MBIN_REQ && (credits_q != '0) && !gnt_q;
        gnt_d     = grant;
        last_col  = (nx_q == mbw_q - MBW_BITS'(1));
        last_row  = (ny_q == mbh_q - MBW_BITS'(1));
        slice_inc = (slice_cnt_q == '1) ? slice_cnt_q : slice_cnt_q + SLICE_BITS'(1);

        if (ack_end && !ack_rd && inflight_q != '1)
            inflight_d = inflight_q + CW'(1);
        else if (!ack_end && ack_rd)
            inflight_d = inflight_q - CW'(1);

        if (grant && !ack_end && pend_q != '1)
            pend_d = pend_q + CW'(1);
        else if (!grant && ack_end)
            pend_d = pend_q - CW'(1);

        if (grant && !ack_rd)
            credits_d = credits_q - CW'(1);
        else if (!grant && ack_rd && credits_q != SLOTS_C)
            credits_d = credits_q + CW'(1);

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    mbw_d       = (MBW == '0) ? MBW_BITS'(1) : MBW;
                    mbh_d       = (MBH == '0) ? MBW_BITS'(1) : MBH;
                    slice_mbs_d = SLICE_MBS;
                    slice_cnt_d = '0;
                    nx_d        = '0;
                    ny_d        = '0;
                    mbx_d       = '0;
                    mby_d       = '0;
                    state_d     = S_DRAIN;
                end
            end
            // Outstanding grants are drained too, so nothing is still being written at NEWSLICE.
            S_DRAIN: begin
                if (inflight_q == '0 && pend_q == '0 && BUF_DONE)
                    state_d = S_SLICE;
            end
            S_SLICE: begin
                NEWSLICE    = 1'b1;
                slice_cnt_d = '0;
                state_d     = S_RUN;
            end
            S_RUN: begin
                if (grant) begin
                    MBIN_GNT    = 1'b1;
                    mbx_d       = nx_q;
                    mby_d       = ny_q;
                    slice_cnt_d = slice_inc;
                    if (last_col && last_row) begin
                        state_d = S_FLUSH;
                    end else begin
                        if (last_col) begin
                            nx_d = '0;
                            ny_d = ny_q + MBW_BITS'(1);
                        end else begin
                            nx_d = nx_q + MBW_BITS'(1);
                        end
                        if (slice_mbs_q != '0 && slice_inc == slice_mbs_q)
                            state_d = S_DRAIN;
                        else if (last_col)
                            state_d = S_LINE;
                    end
                end
            end
            S_LINE: begin
                NEWLINE = 1'b1;
                state_d = S_RUN;
            end
            S_FLUSH: begin
                if (inflight_q == '0 && pend_q == '0) begin
                    FRAME_DONE = 1'b1;
                    state_d    = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            mbw_q       <= '0;
            mbh_q       <= '0;
            slice_mbs_q <= '0;
            slice_cnt_q <= '0;
            nx_q        <= '0;
            ny_q        <= '0;
            mbx_q       <= '0;
            mby_q       <= '0;
            credits_q   <= SLOTS_C;
            inflight_q  <= '0;
            pend_q      <= '0;
            gnt_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mbw_q       <= mbw_d;
            mbh_q       <= mbh_d;
            slice_mbs_q <= slice_mbs_d;
            slice_cnt_q <= slice_cnt_d;
            nx_q        <= nx_d;
            ny_q        <= ny_d;
            mbx_q       <= mbx_d;
            mby_q       <= mby_d;
            credits_q   <= credits_d;
            inflight_q  <= inflight_d;
            pend_q      <= pend_d;
            gnt_q       <= gnt_d;
        end
    end

    assign MBX = mbx_q;
    assign MBY = mby_q;

`ifdef H264BUFFER_SCHED_STATS_EN
    always_comb begin
        stall_d = stall_q;
        mbcnt_d = mbcnt_q;
        if (state_q == S_IDLE && START) begin
            stall_d = '0;
            mbcnt_d = '0;
        end else begin
            if (state_q == S_RUN && MBIN_REQ && credits_q == '0 && stall_q != '1)
                stall_d = stall_q + 16'd1;
            if (grant && mbcnt_q != '1)
                mbcnt_d = mbcnt_q + 16'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            stall_q <= '0;
            mbcnt_q <= '0;
        end else begin
            stall_q <= stall_d;
            mbcnt_q <= mbcnt_d;
        end
    end

    assign STALL_CNT = stall_q;
    assign MB_CNT    = mbcnt_q;
`endif

endmodule

// File: tb/tb_h264buffer_sched.sv
// Directed bench for h264buffer_sched; define H264BUFFER_SCHED_STATS_EN to also check the stats outputs.
module tb_h264buffer_sched;

    logic        CLK = 1'b0;
    logic        RST, START, MBIN_REQ, MBIN_END, MBOUT_END, BUF_DONE;
    logic [7:0]  MBW, MBH, MBX, MBY;
    logic [15:0] SLICE_MBS;
    logic        MBIN_GNT, NEWSLICE, NEWLINE, BUSY, FRAME_DONE;
`ifdef H264BUFFER_SCHED_STATS_EN
    logic [15:0] STALL_CNT, MB_CNT;
`endif

    h264buffer_sched #(.MBW_BITS(8), .SLOTS(2), .SLICE_BITS(16)) dut (
        .CLK(CLK), .RST(RST), .START(START), .MBW(MBW), .MBH(MBH), .SLICE_MBS(SLICE_MBS),
        .MBIN_REQ(MBIN_REQ), .MBIN_GNT(MBIN_GNT), .MBIN_END(MBIN_END), .MBOUT_END(MBOUT_END),
        .BUF_DONE(BUF_DONE), .NEWSLICE(NEWSLICE), .NEWLINE(NEWLINE), .MBX(MBX), .MBY(MBY),
        .BUSY(BUSY), .FRAME_DONE(FRAME_DONE)
`ifdef H264BUFFER_SCHED_STATS_EN
        , .STALL_CNT(STALL_CNT), .MB_CNT(MB_CNT)
`endif
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    bit auto_end, auto_read, end_arm, rd_arm, cap;
    bit man_end, man_rd, man_start;
    int gcnt, nscnt, nlcnt, fdcnt, rdcnt;
    int g_cyc[0:31], gx[0:31], gy[0:31], ns_cyc[0:7], nl_cyc[0:7], rd_cyc[0:31];

    task automatic clear_log();
        gcnt = 0; nscnt = 0; nlcnt = 0; fdcnt = 0; rdcnt = 0;
        end_arm = 0; rd_arm = 0; cap = 0;
        man_end = 0; man_rd = 0; man_start = 0;
    endtask

    // One clock: sample outputs at the falling edge, then drive the next inputs.
    task automatic cycle();
        bit new_end, new_rd;
        @(negedge CLK);
        cyc++;
        if (cap) begin
            if (gcnt <= 32) begin gx[gcnt-1] = MBX; gy[gcnt-1] = MBY; end
            cap = 0;
        end
        new_end = auto_end && end_arm;
        new_rd  = auto_read && rd_arm;
        if (new_end) begin end_arm = 0; rd_arm = 1; end
        if (new_rd) rd_arm = 0;
        if (MBIN_GNT) begin
            if (gcnt < 32) g_cyc[gcnt] = cyc;
            gcnt++;
            cap = 1;
            end_arm = 1;
        end
        if (NEWSLICE) begin if (nscnt < 8) ns_cyc[nscnt] = cyc; nscnt++; end
        if (NEWLINE)  begin if (nlcnt < 8) nl_cyc[nlcnt] = cyc; nlcnt++; end
        if (FRAME_DONE) fdcnt++;
        MBIN_END  = new_end || man_end;
        MBOUT_END = new_rd || man_rd;
        START     = man_start;
        if (MBOUT_END) begin if (rdcnt < 32) rd_cyc[rdcnt] = cyc; rdcnt++; end
        man_end = 0; man_rd = 0; man_start = 0;
    endtask

    task automatic run_cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    // which: 0 waits for gcnt >= target, 1 waits for fdcnt >= target.
    task automatic run_until(input int which, input int target, input int budget, input string name);
        int k;
        k = 0;
        while (((which == 0) ? gcnt : fdcnt) < target && k < budget) begin
            cycle();
            k++;
        end
        n_checks++;
        if (((which == 0) ? gcnt : fdcnt) < target) begin
            n_fail++;
            $display("FAIL %s: timeout, count %0d required %0d", name,
                     (which == 0) ? gcnt : fdcnt, target);
        end
    endtask

    task automatic start_frame(input int w, input int h, input int s);
        MBW = 8'(w); MBH = 8'(h); SLICE_MBS = 16'(s);
        man_start = 1;
        cycle();
    endtask

    task automatic test_reset();
        logic [22:0] outs;
        RST = 1; START = 0; MBIN_REQ = 0; MBIN_END = 0; MBOUT_END = 0; BUF_DONE = 1;
        MBW = 0; MBH = 0; SLICE_MBS = 0;
        clear_log();
        run_cycles(3);
        outs = {MBIN_GNT, NEWSLICE, NEWLINE, MBX, MBY, BUSY, FRAME_DONE, 2'b00};
        n_checks++;
        if (outs !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h required 0", outs);
        end
`ifdef H264BUFFER_SCHED_STATS_EN
        n_checks++;
        if ({STALL_CNT, MB_CNT} !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_stats: got %h required 0", {STALL_CNT, MB_CNT});
        end
`endif
        RST = 0;
        cycle();
        man_end = 1; man_rd = 1; cycle();
        man_end = 1; cycle();
        run_cycles(2);
        n_checks++;
        if (BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_spurious_busy: got %b required 0", BUSY);
        end
    endtask

    task automatic test_frame();
        clear_log();
        auto_end = 1; auto_read = 1; MBIN_REQ = 1;
        start_frame(3, 2, 0);
        run_until(0, 1, 20, "frame_first_grant");
        MBW = 1; man_start = 1; cycle();
        run_until(1, 1, 200, "frame_done_wait");
        run_cycles(4);
        n_checks++;
        if (gcnt !== 6) begin n_fail++; $display("FAIL frame_grants: got %0d required 6", gcnt); end
        n_checks++;
        if (nscnt !== 1 || ns_cyc[0] >= g_cyc[0]) begin
            n_fail++;
            $display("FAIL frame_newslice: count %0d cyc %0d, required 1 before grant cyc %0d",
                     nscnt, ns_cyc[0], g_cyc[0]);
        end
        n_checks++;
        if (nlcnt !== 1 || nl_cyc[0] <= g_cyc[2] || nl_cyc[0] >= g_cyc[3]) begin
            n_fail++;
            $display("FAIL frame_newline: count %0d cyc %0d, required 1 in (%0d,%0d)",
                     nlcnt, nl_cyc[0], g_cyc[2], g_cyc[3]);
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (gx[i] !== i % 3 || gy[i] !== i / 3) begin
                n_fail++;
                $display("FAIL frame_pos%0d: got (%0d,%0d) required (%0d,%0d)",
                         i, gx[i], gy[i], i % 3, i / 3);
            end
        end
        n_checks++;
        if (fdcnt !== 1 || BUSY !== 1'b0 || MBX !== 8'd2 || MBY !== 8'd1) begin
            n_fail++;
            $display("FAIL frame_end: done %0d busy %b pos (%0d,%0d), required 1 0 (2,1)",
                     fdcnt, BUSY, MBX, MBY);
        end
`ifdef H264BUFFER_SCHED_STATS_EN
        n_checks++;
        if (MB_CNT !== 16'd6) begin n_fail++; $display("FAIL mb_cnt: got %0d required 6", MB_CNT); end
`endif
    endtask

    task automatic test_backpressure();
`ifdef H264BUFFER_SCHED_STATS_EN
        logic [15:0] s0;
`endif
        clear_log();
        auto_end = 1; auto_read = 0; MBIN_REQ = 1;
        start_frame(4, 1, 0);
        run_cycles(20);
        n_checks++;
        if (gcnt !== 2) begin n_fail++; $display("FAIL bp_stall: got %0d grants required 2", gcnt); end
`ifdef H264BUFFER_SCHED_STATS_EN
        s0 = STALL_CNT;
        run_cycles(10);
        n_checks++;
        if (STALL_CNT - s0 !== 16'd10) begin
            n_fail++;
            $display("FAIL stall_cnt: got %0d stall cycles required 10", STALL_CNT - s0);
        end
`endif
        man_rd = 1; cycle(); run_cycles(10);
        n_checks++;
        if (gcnt !== 3) begin n_fail++; $display("FAIL bp_release1: got %0d grants required 3", gcnt); end
        man_rd = 1; cycle(); run_cycles(10);
        n_checks++;
        if (gcnt !== 4) begin n_fail++; $display("FAIL bp_release2: got %0d grants required 4", gcnt); end
        man_rd = 1; cycle(); run_cycles(5);
        n_checks++;
        if (fdcnt !== 0) begin n_fail++; $display("FAIL bp_early_done: got %0d required 0", fdcnt); end
        man_rd = 1; cycle();
        run_until(1, 1, 20, "bp_done_wait");
    endtask

    task automatic test_slices();
        clear_log();
        auto_end = 1; auto_read = 1; MBIN_REQ = 1; BUF_DONE = 1;
        start_frame(2, 2, 2);
        run_until(0, 2, 100, "slice_first_pair");
        BUF_DONE = 0;
        run_cycles(12);
        n_checks++;
        if (nscnt !== 1 || gcnt !== 2) begin
            n_fail++;
            $display("FAIL slice_bufdone_hold: newslice %0d grants %0d required 1 2", nscnt, gcnt);
        end
        BUF_DONE = 1;
        run_until(1, 1, 200, "slice_done_wait");
        n_checks++;
        if (gcnt !== 4 || nscnt !== 2) begin
            n_fail++;
            $display("FAIL slice_counts: grants %0d newslice %0d required 4 2", gcnt, nscnt);
        end
        n_checks++;
        if (ns_cyc[1] <= g_cyc[1] || ns_cyc[1] >= g_cyc[2] || ns_cyc[1] <= rd_cyc[1]) begin
            n_fail++;
            $display("FAIL slice_order: newslice cyc %0d, required after %0d/%0d and before %0d",
                     ns_cyc[1], g_cyc[1], rd_cyc[1], g_cyc[2]);
        end
        n_checks++;
        if (nlcnt !== 0) begin n_fail++; $display("FAIL slice_newline: got %0d required 0", nlcnt); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (gx[i] !== i % 2 || gy[i] !== i / 2) begin
                n_fail++;
                $display("FAIL slice_pos%0d: got (%0d,%0d) required (%0d,%0d)",
                         i, gx[i], gy[i], i % 2, i / 2);
            end
        end
    endtask

    task automatic test_simultaneous();
        clear_log();
        auto_end = 0; auto_read = 0; MBIN_REQ = 1;
        start_frame(4, 1, 0);
        run_until(0, 1, 20, "sim_grant1");
        cycle(); man_end = 1; cycle();
        run_until(0, 2, 10, "sim_grant2");
        run_cycles(5);
        n_checks++;
        if (gcnt !== 2) begin n_fail++; $display("FAIL sim_pre: got %0d grants required 2", gcnt); end
        man_end = 1; man_rd = 1; cycle();
        run_cycles(8);
        n_checks++;
        if (gcnt !== 3) begin n_fail++; $display("FAIL sim_credit: got %0d grants required 3", gcnt); end
        man_end = 1; cycle();
        man_rd = 1; cycle();
        run_until(0, 4, 10, "sim_grant4");
        cycle(); man_end = 1; cycle();
        man_rd = 1; cycle();
        run_cycles(5);
        n_checks++;
        if (fdcnt !== 0) begin n_fail++; $display("FAIL sim_inflight: done %0d required 0", fdcnt); end
        man_rd = 1; cycle();
        run_until(1, 1, 10, "sim_done_wait");
    endtask

    task automatic test_reset_midframe();
        logic [21:0] outs;
        clear_log();
        auto_end = 1; auto_read = 1; MBIN_REQ = 1;
        start_frame(4, 4, 0);
        run_until(0, 2, 50, "rst_grant2");
        RST = 1;
        cycle();
        outs = {MBIN_GNT, NEWSLICE, NEWLINE, MBX, MBY, BUSY, FRAME_DONE, 1'b0};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h required 0", outs); end
        RST = 0;
        clear_log();
        run_cycles(6);
        n_checks++;
        if (nscnt !== 0 || BUSY !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_quiet: newslice %0d busy %b required 0 0", nscnt, BUSY);
        end
        start_frame(4, 4, 0);
        run_until(0, 1, 20, "rst_restart_grant");
        cycle();
        n_checks++;
        if (nscnt !== 1 || ns_cyc[0] >= g_cyc[0] || gx[0] !== 0 || gy[0] !== 0) begin
            n_fail++;
            $display("FAIL rst_restart: newslice %0d pos (%0d,%0d) required 1 (0,0)", nscnt, gx[0], gy[0]);
        end
        RST = 1; cycle(); RST = 0; cycle();
    endtask

    initial begin
        test_reset();
        test_frame();
        test_backpressure();
        test_slices();
        test_simultaneous();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
